// File: rtl/giro_quad_decoder.sv
// Quadrature rotation decoder: sync + glitch filter on d1/d2, x4 Gray-code step decode, position count, direction FSM.
// Latency: an input change sampled at edge 0 and held updates step/count/x1/x2 at edge FILT_LEN+2.
// Backpressure: none; en=0 freezes count, flags, FSM and idle timer while the reference pair keeps tracking.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   d1, d2           raw sensor lines A/B, asynchronous to clk
//   en               step enable (0 = count and direction frozen)
//   clr              synchronous clear of count, err, ovf (wins over a coincident step)
//   x1, x2           registered direction flags (forward / reverse), never both 1
//   step             one-cycle pulse per accepted legal step
//   count            CNT_W-bit position count
//   err, ovf         sticky illegal-transition and wrap/saturation flags
//
// Build option: define GIRO_QUAD_SAT_EN to make count saturate at its ends instead of wrapping.

module giro_quad_decoder #(
  parameter int CNT_W    = 8,
  parameter int FILT_LEN = 2,
  parameter int IDLE_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d1,
  input  logic             d2,
  input  logic             en,
  input  logic             clr,
  output logic             x1,
  output logic             x2,
  output logic             step,
  output logic [CNT_W-1:0] count,
  output logic             err,
  output logic             ovf
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(IDLE_CYC + 1);
  localparam int PW = $clog2(FILT_LEN + 3);

  localparam logic [FW-1:0]    FILT_LAST  = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0]    TMR_LAST   = TW'(IDLE_CYC - 1);
  localparam logic [PW-1:0]    PRIME_LAST = PW'(FILT_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_REV  = 2'd2
  } state_t;

  // Input path: bit 0 = d1, bit 1 = d2
  logic [1:0]         meta_q, sync_q;
  logic [1:0]         f_q, f_d;
  logic [1:0][FW-1:0] fcnt_q, fcnt_d;
  logic [1:0]         q_q;
  logic [PW-1:0]      pcnt_q, pcnt_d;
  logic               primed_q, primed_d;

  // Decode / datapath
  logic               fwd, rev, ill, act;
  logic               step_q, step_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;

  // Direction FSM
  state_t             state_q, state_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic               x1_q, x1_d, x2_q, x2_d;

  // Stability filter: f follows sync only after FILT_LEN consecutive differing cycles;
  // any cycle where sync agrees with f again discards the partial run.
  always_comb begin
    f_d    = f_q;
    fcnt_d = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync_q[b] != f_q[b]) begin
        if (fcnt_q[b] == FILT_LAST) begin
          f_d[b] = sync_q[b];
        end else begin
          fcnt_d[b] = fcnt_q[b] + 1'b1;
        end
      end
    end
  end

  // The filter output is only trustworthy once the synchroniser and filter have
  // flushed their reset values; until then q just tracks f and nothing is decoded.
  always_comb begin
    pcnt_d   = (pcnt_q == PRIME_LAST) ? pcnt_q : pcnt_q + 1'b1;
    primed_d = primed_q | (pcnt_q == PRIME_LAST);
  end

  // Gray-code decode of old reference q against new filtered pair {f2,f1}
  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    case ({q_q, f_q})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: rev = 1'b1;
      default: ;
    endcase
    ill = ((q_q ^ f_q) == 2'b11);
    act = en & primed_q;
  end

  // Count / flags
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    step_d  = 1'b0;
    if (clr) begin
      count_d = '0;
      err_d   = 1'b0;
      ovf_d   = 1'b0;
    end else if (act) begin
      if (ill) begin
        err_d = 1'b1;
      end else if (fwd) begin
        step_d = 1'b1;
        if (count_q == CNT_MAX) begin
          ovf_d = 1'b1;
`ifdef GIRO_QUAD_SAT_EN
          count_d = count_q;
`else
          count_d = '0;
`endif
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end else if (rev) begin
        step_d = 1'b1;
        if (count_q == '0) begin
          ovf_d = 1'b1;
`ifdef GIRO_QUAD_SAT_EN
          count_d = count_q;
`else
          count_d = CNT_MAX;
`endif
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
    end
  end

  // FSM next state; a step always takes precedence over an expiring timer
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    if (act) begin
      if (ill) begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end else if (fwd) begin
        state_d = S_FWD;
        tmr_d   = '0;
      end else if (rev) begin
        state_d = S_REV;
        tmr_d   = '0;
      end else if (state_q != S_IDLE) begin
        if (tmr_q == TMR_LAST) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
    end
  end

  // FSM outputs, decoded from the next state so the registered flags equal the state
  always_comb begin
    x1_d = (state_d == S_FWD);
    x2_d = (state_d == S_REV);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= '0;
      sync_q   <= '0;
      f_q      <= '0;
      fcnt_q   <= '0;
      q_q      <= '0;
      pcnt_q   <= '0;
      primed_q <= 1'b0;
      step_q   <= 1'b0;
      count_q  <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      x1_q     <= 1'b0;
      x2_q     <= 1'b0;
    end else begin
      meta_q   <= {d2, d1};
      sync_q   <= meta_q;
      f_q      <= f_d;
      fcnt_q   <= fcnt_d;
      q_q      <= f_q;
      pcnt_q   <= pcnt_d;
      primed_q <= primed_d;
      step_q   <= step_d;
      count_q  <= count_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
    end
  end

  assign x1    = x1_q;
  assign x2    = x2_q;
  assign step  = step_q;
  assign count = count_q;
  assign err   = err_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_giro_quad_decoder.sv
// Self-checking bench for giro_quad_decoder at default parameters.
// Table-driven vectors plus hand sequences for glitch, timeout, reset and clr corners.
// Every step pulse pops the expected count from a scoreboard queue.

module tb_giro_quad_decoder;

  logic       clk = 1'b0;
  logic       rst, d1, d2, en, clr;
  logic       x1, x2, step, err, ovf;
  logic [7:0] count;

  always #5 clk = ~clk;

  giro_quad_decoder #(
    .CNT_W   (8),
    .FILT_LEN(2),
    .IDLE_CYC(255)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .d1   (d1),
    .d2   (d2),
    .en   (en),
    .clr  (clr),
    .x1   (x1),
    .x2   (x2),
    .step (step),
    .count(count),
    .err  (err),
    .ovf  (ovf)
  );

`ifdef GIRO_QUAD_SAT_EN
  localparam logic [7:0] C_REV0 = 8'd0;
  localparam logic [7:0] C_FWD1 = 8'd1;
`else
  localparam logic [7:0] C_REV0 = 8'd255;
  localparam logic [7:0] C_FWD1 = 8'd0;
`endif

  typedef struct {
    logic [1:0] d;     // {d2,d1}
    logic       en;
    logic       clr;
    logic       stp;   // a step pulse is expected
    logic [7:0] cnt;
    logic [1:0] x;     // {x1,x2}
    logic       e;
    logic       o;
  } vec_t;

  vec_t       tbl[14];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb[$];
  bit         saw_step;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any step pulse seen there
  task automatic tick();
    logic [7:0] exp;
    @(negedge clk);
    saw_step = 1'b0;
    if (!rst && step) begin
      saw_step = 1'b1;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_step: got pulse with count=%0d, expected no pulse", count);
      end else begin
        exp = sb.pop_front();
        if (count != exp) begin
          n_bad++;
          $display("FAIL step_count: got %0d, expected %0d", count, exp);
        end
      end
    end
  endtask

  task automatic wait_step(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = saw_step;
    end
    chk(name, int'(got), 1);
  endtask

  task automatic drive(input logic [1:0] d);
    {d2, d1} = d;
  endtask

  initial begin
    logic [1:0] seq[4];
    int         k;
    bit         found, x_bad, got;

    rst = 1'b1; d1 = 1'b0; d2 = 1'b0; en = 1'b1; clr = 1'b0;

    //            d      en    clr   stp   cnt     x      e     o
    tbl[0]  = '{2'b01, 1'b1, 1'b0, 1'b1, 8'd1,   2'b10, 1'b0, 1'b0};
    tbl[1]  = '{2'b11, 1'b1, 1'b0, 1'b1, 8'd2,   2'b10, 1'b0, 1'b0};
    tbl[2]  = '{2'b10, 1'b1, 1'b0, 1'b1, 8'd3,   2'b10, 1'b0, 1'b0};
    tbl[3]  = '{2'b00, 1'b1, 1'b0, 1'b1, 8'd4,   2'b10, 1'b0, 1'b0};
    tbl[4]  = '{2'b10, 1'b1, 1'b0, 1'b1, 8'd3,   2'b01, 1'b0, 1'b0};
    tbl[5]  = '{2'b11, 1'b1, 1'b0, 1'b1, 8'd2,   2'b01, 1'b0, 1'b0};
    tbl[6]  = '{2'b01, 1'b0, 1'b0, 1'b0, 8'd2,   2'b01, 1'b0, 1'b0};
    tbl[7]  = '{2'b01, 1'b1, 1'b0, 1'b0, 8'd2,   2'b01, 1'b0, 1'b0};
    tbl[8]  = '{2'b11, 1'b1, 1'b0, 1'b1, 8'd3,   2'b10, 1'b0, 1'b0};
    tbl[9]  = '{2'b00, 1'b1, 1'b0, 1'b0, 8'd3,   2'b00, 1'b1, 1'b0};
    tbl[10] = '{2'b00, 1'b1, 1'b1, 1'b0, 8'd0,   2'b00, 1'b0, 1'b0};
    tbl[11] = '{2'b10, 1'b1, 1'b0, 1'b1, C_REV0, 2'b01, 1'b0, 1'b1};
    tbl[12] = '{2'b00, 1'b1, 1'b0, 1'b1, C_FWD1, 2'b10, 1'b0, 1'b1};
    tbl[13] = '{2'b00, 1'b1, 1'b1, 1'b0, 8'd0,   2'b10, 1'b0, 1'b0};

    // Reset state
    tick();
    tick();
    chk("rst_count", count, 0);
    chk("rst_x", {x1, x2}, 0);
    chk("rst_step", step, 0);
    chk("rst_err", err, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    repeat (10) tick();

    // Table vectors, each held 8 cycles
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].d);
      en  = tbl[i].en;
      clr = tbl[i].clr;
      if (tbl[i].stp) sb.push_back(tbl[i].cnt);
      repeat (8) tick();
      chk($sformatf("v%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("v%0d_x", i), {x1, x2}, tbl[i].x);
      chk($sformatf("v%0d_err", i), err, tbl[i].e);
      chk($sformatf("v%0d_ovf", i), ovf, tbl[i].o);
      chk($sformatf("v%0d_sb_empty", i), sb.size(), 0);
    end
    clr = 1'b0;
    en  = 1'b1;
    repeat (2) tick();

    // One-cycle glitch on d1 is discarded
    d1 = 1'b1;
    tick();
    d1 = 1'b0;
    repeat (10) tick();
    chk("glitch1_count", count, 0);
    chk("glitch1_err", err, 0);

    // Two-cycle pulse passes: forward then reverse
    sb.push_back(8'd1);
    sb.push_back(8'd0);
    d1 = 1'b1;
    tick();
    tick();
    d1 = 1'b0;
    repeat (12) tick();
    chk("glitch2_count", count, 0);
    chk("glitch2_sb_empty", sb.size(), 0);
    chk("glitch2_err", err, 0);

    // Idle timeout: x1 drops exactly 255 edges after the step edge
    sb.push_back(8'd1);
    drive(2'b01);
    wait_step("timeout_step_seen");
    chk("timeout_x_at_step", {x1, x2}, 2'b10);
    k = 0;
    found = 1'b0;
    for (int i = 1; i <= 400 && !found; i++) begin
      tick();
      if (!x1) begin
        found = 1'b1;
        k = i;
      end
    end
    chk("timeout_edges", k, 255);
    chk("timeout_x_idle", {x1, x2}, 2'b00);

    // Reverse step 100 cycles after a forward step: FWD -> REV directly
    sb.push_back(8'd2);
    drive(2'b11);
    wait_step("dir_fwd_step_seen");
    repeat (100) tick();
    sb.push_back(8'd1);
    drive(2'b01);
    x_bad = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = saw_step;
      if (!got && {x1, x2} != 2'b10) x_bad = 1'b1;
    end
    chk("dir_rev_step_seen", int'(got), 1);
    chk("dir_rev_x", {x1, x2}, 2'b01);
    chk("dir_no_idle_gap", int'(x_bad), 0);

    // Build count 37 with inputs ending at 11
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("pre37_count", count, 0);
    seq[0] = 2'b11; seq[1] = 2'b10; seq[2] = 2'b00; seq[3] = 2'b01;
    for (int i = 0; i < 37; i++) begin
      drive(seq[i % 4]);
      sb.push_back(8'(i + 1));
      repeat (6) tick();
    end
    chk("c37_count", count, 37);
    chk("c37_sb_empty", sb.size(), 0);
    chk("c37_x", {x1, x2}, 2'b10);

    // Asynchronous reset mid-operation with inputs at 11
    #2 rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_x", {x1, x2}, 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (12) tick();
    chk("reprime_count", count, 0);
    chk("reprime_x", {x1, x2}, 0);
    chk("reprime_err", err, 0);
    chk("reprime_ovf", ovf, 0);

    // clr on the exact step edge: step dropped
    drive(2'b10);
    repeat (4) tick();
    clr = 1'b1;
    tick();
    chk("clrstep_count", count, 0);
    chk("clrstep_step", step, 0);
    chk("clrstep_ovf", ovf, 0);
    clr = 1'b0;
    sb.push_back(8'd1);
    drive(2'b00);
    repeat (8) tick();
    chk("after_clr_count", count, 1);
    chk("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
